// File: rtl/arb_pkg.sv
// Shared definitions for the two-master memory arbiter: state encoding and master indices.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter with burst limit sharing one combinational-read memory port
// between the CPU core (master 0) and a loader/DMA requester (master 1).
module mem_arbiter
  import arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  output logic                  m0_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_t    state_reg, state_next;
  logic          last_owner_reg, last_owner_next;
  logic [CW-1:0] burst_cnt_reg, burst_cnt_next;

  logic          owner_is_m1;
  logic          owner_req;
  logic          other_req;
  logic          owner_we;
  logic [CW:0]   cnt_inc;
  logic          burst_done;
  logic          cnt_sat;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      last_owner_reg <= M1;
      burst_cnt_reg  <= '0;
    end else begin
      state_reg      <= state_next;
      last_owner_reg <= last_owner_next;
      burst_cnt_reg  <= burst_cnt_next;
    end
  end

  // Grants depend only on registered ownership, so a reset drops them at once.
  assign m0_gnt = (state_reg == OWN0) & m0_req;
  assign m1_gnt = (state_reg == OWN1) & m1_req;

  assign m0_rdata = mem_rdata;
  assign m1_rdata = mem_rdata;

  always_comb begin
    owner_we  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_reg)
      OWN0: begin
        owner_we  = m0_we;
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
      end
      OWN1: begin
        owner_we  = m1_we;
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
      end
      default: ;
    endcase
  end

  assign mem_we = owner_we & (m0_gnt | m1_gnt);

  assign owner_is_m1 = (state_reg == OWN1);
  assign owner_req   = owner_is_m1 ? m1_req : m0_req;
  assign other_req   = owner_is_m1 ? m0_req : m1_req;
  assign cnt_inc     = {1'b0, burst_cnt_reg} + (CW+1)'(1);
  assign burst_done  = cnt_inc >= (CW+1)'(MAX_BURST);
  assign cnt_sat     = burst_cnt_reg == CW'(MAX_BURST);

  always_comb begin
    state_next      = state_reg;
    last_owner_next = last_owner_reg;
    burst_cnt_next  = burst_cnt_reg;
    case (state_reg)
      IDLE: begin
        burst_cnt_next = '0;
        if (m0_req && m1_req)
          state_next = (last_owner_reg == M1) ? OWN0 : OWN1;
        else if (m0_req)
          state_next = OWN0;
        else if (m1_req)
          state_next = OWN1;
      end
      OWN0, OWN1: begin
        // Hand off when the owner is done or has used up its burst while the other waits.
        if (other_req && (!owner_req || burst_done)) begin
          state_next      = owner_is_m1 ? OWN0 : OWN1;
          burst_cnt_next  = '0;
          last_owner_next = owner_is_m1 ? M1 : M0;
        end else if (owner_req) begin
          if (!cnt_sat)
            burst_cnt_next = cnt_inc[CW-1:0];
        end else begin
          state_next      = IDLE;
          last_owner_next = owner_is_m1 ? M1 : M0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter sharing the single unified instruction/data memory port between the CPU core (master 0) and a secondary requester such as a program loader or DMA engine (master 1). It sits between the masters and the memory-map controller that decodes memory versus GPIO. It grants one master per cycle using round-robin priority with a burst limit, so neither master can starve the other. Memory reads are combinational; writes commit on the clock edge.

## Interface
- DATA_WIDTH, 32, width of data buses
- ADDR_WIDTH, 32, width of address buses
- MAX_BURST, 8, maximum consecutive granted accesses by one master while the other master is requesting; must be at least 1

- clk  in  1  single system clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- m0_req, m1_req  in  1  access request, held until granted
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  ADDR_WIDTH  byte address
- m0_wdata, m1_wdata  in  DATA_WIDTH  write data
- m0_gnt, m1_gnt  out  1  access completes this cycle
- m0_rdata, m1_rdata  out  DATA_WIDTH  read data; valid only while the matching gnt = 1
- mem_addr  out  ADDR_WIDTH  to memory controller
- mem_wdata  out  DATA_WIDTH  to memory controller
- mem_we  out  1  memory write strobe
- mem_rdata  in  DATA_WIDTH  combinational read data from memory controller

## Operation
- States: IDLE, OWN0, OWN1. Registers: state, last_owner (1 bit), burst_cnt (width $clog2(MAX_BURST+1)).
- Grant logic is combinational from the registered state:
  - m0_gnt = (state==OWN0) & m0_req
  - m1_gnt = (state==OWN1) & m1_req
- Memory mux:
  - mem_addr, mem_wdata and mem_we come from the owner.
  - mem_we = owner_we & owner_gnt. It is never asserted in IDLE, or when the owner has dropped its request.
  - In IDLE, mem_addr and mem_wdata are 0.
- Both rdata outputs always carry mem_rdata. A master uses its rdata only in a cycle where its gnt = 1.
- Transitions (evaluated at each rising edge):
  - IDLE, no requests -> IDLE.
  - IDLE, one request -> that master's OWN state.
  - IDLE, both requesting -> OWN of the master that is not last_owner.
  - OWNx, owner requesting, other idle -> stay. burst_cnt saturates at MAX_BURST.
  - OWNx, owner requesting, other requesting, burst_cnt+1 < MAX_BURST -> stay, burst_cnt++.
  - OWNx, owner requesting, other requesting, burst_cnt+1 == MAX_BURST -> OWN of the other master. That final access still completes this cycle.
  - OWNx, owner not requesting, other requesting -> OWN of the other master.
  - OWNx, no requests -> IDLE.
- Bookkeeping on transitions:
  - On every entry into an OWN state, burst_cnt is cleared to 0.
  - On leaving OWNx, last_owner is set to x.
- burst_cnt increments only on cycles where the owner's gnt = 1.

## Timing
- Reset values: state = IDLE, last_owner = 1, burst_cnt = 0. As a result, all gnt = 0, mem_we = 0, mem_addr = 0 and mem_wdata = 0.
- Master 0 wins the first tie after reset.
- Arbitration latency: a request raised in IDLE is granted in the next cycle.
- Once a master owns the port, each cycle with req = 1 is one completed access, so a sustained owner gets full throughput.
- Handoff between masters costs no idle cycle: the last access of the old owner and the first access of the new owner are on adjacent cycles.
- Read data is available in the same cycle as gnt, because the memory read is combinational.
- Write data is committed at the rising edge that ends the gnt cycle.
- The outputs of a non-owner are held stable: its gnt = 0. Its request must stay asserted and its address and data must stay stable until gnt = 1.
- Reset asserted mid-access: gnt and mem_we drop asynchronously in the same cycle, so the in-flight write is not committed.
- Worst-case wait for a requesting master is MAX_BURST + 1 cycles.

## Structure
- Shared package arb_pkg holds:
  - the state encoding (IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2)
  - the master-index constants M0 = 1'b0 and M1 = 1'b1
- Encoding 2'd3 is illegal and must recover to IDLE.
- The block is a single module. The next-state logic, burst counter and output mux are small, so no sub-module is warranted.

## Test plan
- Reset release with m0_req = 1, m0_we = 0, m0_addr = 0x0040_0000: m0_gnt = 0 in cycle 0, then m0_gnt = 1 from cycle 1, and mem_addr = 0x0040_0000.
- Both masters request from IDLE after reset: OWN0 first. After master 0 drops its request, master 1 is granted on the very next cycle. On a later simultaneous request from IDLE, master 0 wins again, because last_owner = 1 after master 1 finished.
- MAX_BURST = 8, both masters requesting continuously: master 0 gets 8 consecutive grants, then master 1 gets 8, alternating with no gap. Exactly one gnt is high per cycle, never both.
- Master 1 writes 0xDEAD_BEEF to 0x1001_0010, then master 0 reads 0x1001_0010: mem_we is high only on the write cycle, and m0_rdata = 0xDEAD_BEEF on the master 0 gnt cycle.
- Reset is asserted during an OWN1 write cycle: m1_gnt and mem_we fall immediately, the memory location keeps its old value, and after reset master 0 wins the tie.
- Master 0 requests alone for 20 cycles: 20 continuous grants, and burst_cnt saturates at 8. Master 1 then requests and is granted on the next cycle.
